// File: rtl/gol_pkg.sv
// Shared types and sizes for the Game-of-Life memory scheduling path.
package gol_pkg;

  localparam int GOL_ADDR_W = 9;
  localparam int GOL_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    WAIT_SWAP = 2'd2
  } sched_state_t;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    DISP = 2'd1,
    ENG  = 2'd2
  } rd_owner_t;

endpackage

// File: rtl/gol_mem_scheduler.sv
// Shares the single-port cell memory between display and update engine and
// sequences generations over two banks that swap on a frame boundary.
//
// state     | meaning
// IDLE      | counting frames until the next generation is due
// RUN       | engine computing into the hidden bank
// WAIT_SWAP | generation finished, swap banks at the next frame_end
module gol_mem_scheduler
  import gol_pkg::*;
#(
  parameter int ADDR_W     = GOL_ADDR_W,
  parameter int DATA_W     = GOL_DATA_W,
  parameter int GEN_FRAMES = 8
) (
  input  logic              clk_25,
  input  logic              rst_n,
  input  logic              run_en,
  input  logic              frame_end,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_gnt,
  output logic              disp_rvalid,
  input  logic              eng_req,
  input  logic              eng_we,
  input  logic [ADDR_W-1:0] eng_addr,
  input  logic [DATA_W-1:0] eng_wdata,
  output logic              eng_gnt,
  output logic              eng_rvalid,
  output logic              gen_start,
  input  logic              gen_done,
  output logic              bank,
  output logic              mem_en,
  output logic              mem_we,
  output logic              mem_bank,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] LAST_FRAME = CNT_W'(GEN_FRAMES - 1);

  sched_state_t     state_q;
  logic [CNT_W-1:0] frame_cnt_q;
  logic             bank_q;
  logic             gen_start_q;
  rd_owner_t        rd_owner_q, rd_owner_d;
  logic             eng_wr;

  // Read data passes straight through; only ownership is tracked here.
  logic unused_rdata;
  assign unused_rdata = ^mem_rdata;

  always_comb begin
    disp_gnt  = disp_req;
    eng_gnt   = eng_req & ~disp_req & (state_q == RUN);
    eng_wr    = eng_gnt & eng_we;
    mem_en    = disp_gnt | eng_gnt;
    mem_we    = eng_wr;
    mem_bank  = eng_wr ? ~bank_q : bank_q;
    mem_addr  = disp_gnt ? disp_addr : eng_addr;
    mem_wdata = eng_wdata;
    rd_owner_d = NONE;
    if (disp_gnt)
      rd_owner_d = DISP;
    else if (eng_gnt && !eng_we)
      rd_owner_d = ENG;
  end

  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      rd_owner_q <= NONE;
    end else begin
      rd_owner_q <= rd_owner_d;
    end
  end

  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      frame_cnt_q <= '0;
      bank_q      <= 1'b0;
      gen_start_q <= 1'b0;
    end else begin
      gen_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (frame_end && run_en) begin
            if (frame_cnt_q == LAST_FRAME) begin
              frame_cnt_q <= '0;
              gen_start_q <= 1'b1;
              state_q     <= RUN;
            end else begin
              frame_cnt_q <= frame_cnt_q + 1'b1;
            end
          end
        end
        // A frame_end coinciding with gen_done is not a swap point.
        RUN: begin
          if (gen_done)
            state_q <= WAIT_SWAP;
        end
        WAIT_SWAP: begin
          if (frame_end) begin
            bank_q  <= ~bank_q;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bank        = bank_q;
  assign gen_start   = gen_start_q;
  assign disp_rvalid = (rd_owner_q == DISP);
  assign eng_rvalid  = (rd_owner_q == ENG);

endmodule

// File: tb/tb_gol_mem_scheduler.sv
// Directed bench for gol_mem_scheduler with GEN_FRAMES=2.
module tb_gol_mem_scheduler;
  import gol_pkg::*;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;

  logic              clk_25 = 1'b0;
  logic              rst_n;
  logic              run_en, frame_end;
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_gnt, disp_rvalid;
  logic              eng_req, eng_we;
  logic [ADDR_W-1:0] eng_addr;
  logic [DATA_W-1:0] eng_wdata;
  logic              eng_gnt, eng_rvalid;
  logic              gen_start, gen_done, bank;
  logic              mem_en, mem_we, mem_bank;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;

  int tests  = 0;
  int failed = 0;
  int any_gnt;

  gol_mem_scheduler #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .GEN_FRAMES(2)) dut (
    .clk_25(clk_25), .rst_n(rst_n), .run_en(run_en), .frame_end(frame_end),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
    .disp_rvalid(disp_rvalid), .eng_req(eng_req), .eng_we(eng_we),
    .eng_addr(eng_addr), .eng_wdata(eng_wdata), .eng_gnt(eng_gnt),
    .eng_rvalid(eng_rvalid), .gen_start(gen_start), .gen_done(gen_done),
    .bank(bank), .mem_en(mem_en), .mem_we(mem_we), .mem_bank(mem_bank),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk_25 = ~clk_25;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_25);
    #1;
  endtask

  task automatic pulse_frame();
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; run_en = 1'b1; frame_end = 1'b0; gen_done = 1'b0;
    disp_req = 1'b0; disp_addr = '0; eng_req = 1'b0; eng_we = 1'b0;
    eng_addr = '0; eng_wdata = '0; mem_rdata = 32'h1234_5678;
    #1;
    check("rst_bank", bank, 0);
    check("rst_gen_start", gen_start, 0);
    check("rst_disp_rvalid", disp_rvalid, 0);
    check("rst_eng_rvalid", eng_rvalid, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_state", dut.state_q, IDLE);
    check("rst_frame_cnt", dut.frame_cnt_q, 0);
    disp_req = 1'b1;
    #1;
    check("rst_disp_gnt_comb", disp_gnt, 1);
    check("rst_mem_en_comb", mem_en, 1);
    disp_req = 1'b0;
    #1 rst_n = 1'b1;
    tick();

    // Generation start after two frames
    pulse_frame();
    check("cnt_after_f1", dut.frame_cnt_q, 1);
    check("gs_after_f1", gen_start, 0);
    frame_end = 1'b1;
    #1;
    check("gs_before_edge", gen_start, 0);
    tick();
    frame_end = 1'b0;
    check("gs_pulse", gen_start, 1);
    check("state_run", dut.state_q, RUN);
    check("cnt_cleared", dut.frame_cnt_q, 0);
    check("bank_gen1", bank, 0);
    tick();
    check("gs_one_cycle", gen_start, 0);

    // frame_end in RUN has no effect
    pulse_frame();
    check("run_frame_state", dut.state_q, RUN);
    check("run_frame_cnt", dut.frame_cnt_q, 0);

    // Display priority over engine read
    disp_req = 1'b1; disp_addr = 9'h010;
    eng_req = 1'b1; eng_we = 1'b0; eng_addr = 9'h005;
    #1;
    check("prio_disp_gnt", disp_gnt, 1);
    check("prio_eng_gnt", eng_gnt, 0);
    check("prio_addr", mem_addr, 9'h010);
    check("prio_bank", mem_bank, 0);
    check("prio_we", mem_we, 0);
    tick();
    check("disp_rvalid", disp_rvalid, 1);
    check("disp_eng_rvalid", eng_rvalid, 0);
    disp_req = 1'b0;
    #1;
    check("eng_rd_gnt", eng_gnt, 1);
    check("eng_rd_bank", mem_bank, 0);
    check("eng_rd_addr", mem_addr, 9'h005);
    check("eng_rd_en", mem_en, 1);
    tick();
    eng_req = 1'b0;
    check("eng_rvalid", eng_rvalid, 1);
    check("eng_rd_disp_rvalid", disp_rvalid, 0);

    // Engine write goes to hidden bank
    eng_req = 1'b1; eng_we = 1'b1; eng_addr = 9'h1FF; eng_wdata = 32'hDEADBEEF;
    #1;
    check("wr_gnt", eng_gnt, 1);
    check("wr_we", mem_we, 1);
    check("wr_bank", mem_bank, 1);
    check("wr_addr", mem_addr, 9'h1FF);
    check("wr_data", mem_wdata, 32'hDEADBEEF);
    tick();
    eng_req = 1'b0; eng_we = 1'b0;
    check("wr_no_eng_rvalid", eng_rvalid, 0);
    check("wr_no_disp_rvalid", disp_rvalid, 0);

    // gen_done coinciding with frame_end: no swap
    gen_done = 1'b1; frame_end = 1'b1;
    tick();
    gen_done = 1'b0; frame_end = 1'b0;
    check("coinc_state", dut.state_q, WAIT_SWAP);
    check("coinc_bank", bank, 0);

    // Engine locked out and stray gen_done ignored in WAIT_SWAP
    eng_req = 1'b1; any_gnt = 0;
    for (int i = 0; i < 50; i++) begin
      if (i == 10) gen_done = 1'b1;
      if (i == 11) gen_done = 1'b0;
      if (eng_gnt) any_gnt++;
      tick();
    end
    check("ws_eng_gnt", any_gnt, 0);
    check("ws_stray_done", dut.state_q, WAIT_SWAP);

    pulse_frame();
    check("swap_bank", bank, 1);
    check("swap_state", dut.state_q, IDLE);

    // IDLE: engine locked out, run_en=0 holds frame count
    run_en = 1'b0; any_gnt = 0;
    for (int i = 0; i < 50; i++) begin
      if (i == 20) frame_end = 1'b1;
      if (i == 21) frame_end = 1'b0;
      if (eng_gnt) any_gnt++;
      tick();
    end
    eng_req = 1'b0;
    check("idle_eng_gnt", any_gnt, 0);
    check("idle_cnt_hold", dut.frame_cnt_q, 0);
    check("idle_no_start", dut.state_q, IDLE);

    // Second generation with bank=1; run_en drops mid-generation
    run_en = 1'b1;
    pulse_frame();
    pulse_frame();
    check("gen2_start", gen_start, 1);
    run_en = 1'b0;
    eng_req = 1'b1; eng_we = 1'b1; eng_addr = 9'h003;
    #1;
    check("gen2_wr_bank", mem_bank, 0);
    tick();
    eng_req = 1'b0; eng_we = 1'b0;
    gen_done = 1'b1;
    tick();
    gen_done = 1'b0;
    check("gen2_ws", dut.state_q, WAIT_SWAP);
    check("gen2_bank_pre", bank, 1);

    // Async reset in WAIT_SWAP with a pending display read
    disp_req = 1'b1; disp_addr = 9'h0AA;
    tick();
    disp_req = 1'b0;
    check("pre_rst_rvalid", disp_rvalid, 1);
    rst_n = 1'b0;
    #1;
    check("arst_bank", bank, 0);
    check("arst_state", dut.state_q, IDLE);
    check("arst_cnt", dut.frame_cnt_q, 0);
    check("arst_rvalid", disp_rvalid, 0);
    #2 rst_n = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
